// File: rtl/lcd_pkg.sv
// Shared constants and types for the character LCD path: arbiter FSM states and
// HD44780 command bytes used by the arbiter and the byte-level bus driver.
package lcd_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetAddr,
      StSendChar,
      StDone
   } lcd_state_e;

   localparam logic [7:0] CMD_CLEAR        = 8'h01;
   localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
   localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
   localparam logic [7:0] CMD_FUNCTION_SET = 8'h38;
   localparam logic [7:0] CMD_SET_DDRAM    = 8'h80;

   localparam logic [6:0] ROW1_BASE_DEFAULT = 7'h40;

   function automatic logic [6:0] ddram_addr(input logic       row,
                                             input logic [3:0] col,
                                             input logic [6:0] row1_base);
      return (row ? row1_base : 7'h00) + {3'b000, col};
   endfunction

endpackage

// File: rtl/lcd_write_arbiter_if.sv
// Requester and bus-driver handshake bundle for lcd_write_arbiter.
// The arbiter takes the slave view; clients and the driver model take master.
interface lcd_write_arbiter_if;

   logic       req0_valid;
   logic       req0_row;
   logic [3:0] req0_col;
   logic [7:0] req0_char;
   logic       req0_ready;

   logic       req1_valid;
   logic       req1_row;
   logic [3:0] req1_col;
   logic [7:0] req1_char;
   logic       req1_ready;

   logic       drv_valid;
   logic       drv_rs;
   logic [7:0] drv_data;
   logic       drv_ready;

   logic       err_pulse;

   modport slave (
      input  req0_valid, req0_row, req0_col, req0_char,
      input  req1_valid, req1_row, req1_col, req1_char,
      input  drv_ready,
      output req0_ready, req1_ready,
      output drv_valid, drv_rs, drv_data,
      output err_pulse
   );

   modport master (
      output req0_valid, req0_row, req0_col, req0_char,
      output req1_valid, req1_row, req1_col, req1_char,
      output drv_ready,
      input  req0_ready, req1_ready,
      input  drv_valid, drv_rs, drv_data,
      input  err_pulse
   );

endinterface

// File: rtl/lcd_rr_arbiter.sv
// Two-input round-robin grant. gnt_id is combinational from the live requests;
// the last_grant history only moves when the owning transaction completes.
module lcd_rr_arbiter (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   input  logic update,
   input  logic upd_id,
   output logic gnt_id
);

   logic last_grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else if (update) begin
         last_grant_q <= upd_id;
      end
   end

   // With no request the value is irrelevant; a lone request wins outright.
   always_comb begin
      gnt_id = (req0 && req1) ? ~last_grant_q : ~req0;
   end

endmodule

// File: rtl/lcd_write_arbiter.sv
// Shares the character LCD between two (row, col, char) requesters, issuing a
// DDRAM set-address only when the tracked cursor does not already point there.
module lcd_write_arbiter
   import lcd_pkg::*;
#(
   parameter int unsigned COLS      = 16,
   parameter logic [6:0]  ROW1_BASE = ROW1_BASE_DEFAULT
) (
   input logic                clk,
   input logic                rst_n,
   lcd_write_arbiter_if.slave bus
);

   lcd_state_e state_q, state_d;
   logic       gnt_q, gnt_d;
   logic [6:0] tgt_q, tgt_d;
   logic [7:0] char_q, char_d;
   logic       last_col_q, last_col_d;
   logic       err_q, err_d;
   logic [6:0] cur_addr_q, cur_addr_d;
   logic       cursor_valid_q, cursor_valid_d;

   logic       drv_valid_q, drv_valid_d;
   logic       drv_rs_q, drv_rs_d;
   logic [7:0] drv_data_q, drv_data_d;
   logic       req0_ready_q, req0_ready_d;
   logic       req1_ready_q, req1_ready_d;
   logic       err_pulse_q, err_pulse_d;

   logic       arb_gnt;
   logic       sel_row;
   logic [3:0] sel_col;
   logic [7:0] sel_char;
   logic [6:0] sel_addr;
   logic       xfer;

   lcd_rr_arbiter u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req0   (bus.req0_valid),
      .req1   (bus.req1_valid),
      .update (state_q == StDone),
      .upd_id (gnt_q),
      .gnt_id (arb_gnt)
   );

   always_comb begin
      sel_row  = arb_gnt ? bus.req1_row  : bus.req0_row;
      sel_col  = arb_gnt ? bus.req1_col  : bus.req0_col;
      sel_char = arb_gnt ? bus.req1_char : bus.req0_char;
      sel_addr = ddram_addr(sel_row, sel_col, ROW1_BASE);
      xfer     = drv_valid_q && bus.drv_ready;

      state_d        = state_q;
      gnt_d          = gnt_q;
      tgt_d          = tgt_q;
      char_d         = char_q;
      last_col_d     = last_col_q;
      err_d          = err_q;
      cur_addr_d     = cur_addr_q;
      cursor_valid_d = cursor_valid_q;

      unique case (state_q)
         StIdle: begin
            if (bus.req0_valid || bus.req1_valid) begin
               gnt_d      = arb_gnt;
               tgt_d      = sel_addr;
               char_d     = sel_char;
               last_col_d = ({28'd0, sel_col} == COLS - 1);
               err_d      = ({28'd0, sel_col} >= COLS);
               if (err_d) begin
                  state_d = StDone;
               end else if (cursor_valid_q && (cur_addr_q == sel_addr)) begin
                  state_d = StSendChar;
               end else begin
                  state_d = StSetAddr;
               end
            end
         end
         StSetAddr: begin
            if (xfer) state_d = StSendChar;
         end
         StSendChar: begin
            if (xfer) begin
               cur_addr_d = tgt_q + 7'd1;
               // No DDRAM wrap model: after the last column always re-address.
               cursor_valid_d = !last_col_q;
               state_d        = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Outputs are registered, so decode them from the next state.
      drv_valid_d  = (state_d == StSetAddr) || (state_d == StSendChar);
      drv_rs_d     = (state_d == StSendChar);
      drv_data_d   = 8'h00;
      if (state_d == StSetAddr) begin
         drv_data_d = CMD_SET_DDRAM | {1'b0, tgt_d};
      end else if (state_d == StSendChar) begin
         drv_data_d = char_d;
      end
      req0_ready_d = (state_d == StDone) && !gnt_d;
      req1_ready_d = (state_d == StDone) && gnt_d;
      err_pulse_d  = (state_d == StDone) && err_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= StIdle;
         gnt_q          <= 1'b0;
         tgt_q          <= 7'h00;
         char_q         <= 8'h00;
         last_col_q     <= 1'b0;
         err_q          <= 1'b0;
         cur_addr_q     <= 7'h00;
         cursor_valid_q <= 1'b0;
         drv_valid_q    <= 1'b0;
         drv_rs_q       <= 1'b0;
         drv_data_q     <= 8'h00;
         req0_ready_q   <= 1'b0;
         req1_ready_q   <= 1'b0;
         err_pulse_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         gnt_q          <= gnt_d;
         tgt_q          <= tgt_d;
         char_q         <= char_d;
         last_col_q     <= last_col_d;
         err_q          <= err_d;
         cur_addr_q     <= cur_addr_d;
         cursor_valid_q <= cursor_valid_d;
         drv_valid_q    <= drv_valid_d;
         drv_rs_q       <= drv_rs_d;
         drv_data_q     <= drv_data_d;
         req0_ready_q   <= req0_ready_d;
         req1_ready_q   <= req1_ready_d;
         err_pulse_q    <= err_pulse_d;
      end
   end

   assign bus.drv_valid  = drv_valid_q;
   assign bus.drv_rs     = drv_rs_q;
   assign bus.drv_data   = drv_data_q;
   assign bus.req0_ready = req0_ready_q;
   assign bus.req1_ready = req1_ready_q;
   assign bus.err_pulse  = err_pulse_q;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// Bench for lcd_write_arbiter: a transaction-script model predicts every cycle's
// outputs; directed scenarios pin latencies and byte values with literals.
module tb_lcd_write_arbiter;

   // ROW1_BASE directly follows the last row-0 cell, so a stale cursor after the
   // last column would wrongly match (row1, col0) and skip its address command.
   localparam int unsigned COLS      = 12;
   localparam logic [6:0]  ROW1_BASE = 7'h0C;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   lcd_write_arbiter_if bus ();

   lcd_write_arbiter #(
      .COLS      (COLS),
      .ROW1_BASE (ROW1_BASE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   bit         p_valid [2];
   bit         p_row   [2];
   logic [3:0] p_col   [2];
   logic [7:0] p_char  [2];
   bit         p_drdy;

   typedef struct {
      bit         is_byte;
      bit         rs;
      logic [7:0] data;
      bit         id;
      bit         err;
   } item_t;

   // Remaining outputs of the current transaction, one entry per visible step.
   item_t      mq[$];
   bit         m_cur_valid;
   int         m_cur_addr;
   bit         m_last;
   logic [8:0] seen[$];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got timeout expected completion at %0t", name, $time);
   endtask

   task automatic drive();
      bus.req0_valid = p_valid[0];
      bus.req0_row   = p_row[0];
      bus.req0_col   = p_col[0];
      bus.req0_char  = p_char[0];
      bus.req1_valid = p_valid[1];
      bus.req1_row   = p_row[1];
      bus.req1_col   = p_col[1];
      bus.req1_char  = p_char[1];
      bus.drv_ready  = p_drdy;
   endtask

   task automatic model_reset();
      mq.delete();
      m_cur_valid = 1'b0;
      m_cur_addr  = 0;
      m_last      = 1'b1;
   endtask

   function automatic item_t mk(bit is_byte, bit rs, logic [7:0] data, bit id, bit err);
      item_t it;
      it.is_byte = is_byte;
      it.rs      = rs;
      it.data    = data;
      it.id      = id;
      it.err     = err;
      return it;
   endfunction

   // Advance the model across the coming clock edge using the driven inputs.
   task automatic model_step();
      int id;
      int addr;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (mq.size() == 0) begin
         if (p_valid[0] || p_valid[1]) begin
            if (p_valid[0] && p_valid[1]) id = m_last ? 0 : 1;
            else id = p_valid[1] ? 1 : 0;
            m_last = id[0];
            addr = (p_row[id] ? int'(ROW1_BASE) : 0) + int'(p_col[id]);
            if (int'(p_col[id]) >= int'(COLS)) begin
               mq.push_back(mk(1'b0, 1'b0, 8'h00, id[0], 1'b1));
            end else begin
               if (!(m_cur_valid && m_cur_addr == addr))
                  mq.push_back(mk(1'b1, 1'b0, 8'(128 + addr), 1'b0, 1'b0));
               mq.push_back(mk(1'b1, 1'b1, p_char[id], 1'b0, 1'b0));
               mq.push_back(mk(1'b0, 1'b0, 8'h00, id[0], 1'b0));
               m_cur_addr  = (addr + 1) % 128;
               m_cur_valid = (int'(p_col[id]) != int'(COLS) - 1);
            end
         end
      end else if (!mq[0].is_byte || p_drdy) begin
         void'(mq.pop_front());
      end
   endtask

   task automatic check_now();
      bit         ev   = 1'b0;
      bit         ers  = 1'b0;
      logic [7:0] ed   = 8'h00;
      bit         e0   = 1'b0;
      bit         e1   = 1'b0;
      bit         eerr = 1'b0;
      if (mq.size() > 0) begin
         if (mq[0].is_byte) begin
            ev  = 1'b1;
            ers = mq[0].rs;
            ed  = mq[0].data;
         end else begin
            e0   = !mq[0].id;
            e1   = mq[0].id;
            eerr = mq[0].err;
         end
      end
      chk("drv_valid", bus.drv_valid, ev);
      if (ev) begin
         chk("drv_rs", bus.drv_rs, ers);
         chk("drv_data", bus.drv_data, ed);
      end
      chk("req0_ready", bus.req0_ready, e0);
      chk("req1_ready", bus.req1_ready, e1);
      chk("err_pulse", bus.err_pulse, eerr);
   endtask

   task automatic tick();
      if (rst_n && bus.drv_valid === 1'b1 && p_drdy) seen.push_back({bus.drv_rs, bus.drv_data});
      drive();
      model_step();
      @(negedge clk);
      check_now();
   endtask

   // Must be entered in an IDLE cycle; leaves the DUT in the following IDLE cycle.
   task automatic do_write(input int id, input bit row, input logic [3:0] col,
                           input logic [7:0] ch, output int lat, output bit got_err);
      p_valid[id] = 1'b1;
      p_row[id]   = row;
      p_col[id]   = col;
      p_char[id]  = ch;
      lat         = -1;
      got_err     = 1'b0;
      seen.delete();
      for (int i = 1; i <= 200; i++) begin
         tick();
         if (((id == 0) ? bus.req0_ready : bus.req1_ready) === 1'b1) begin
            lat     = i;
            got_err = bus.err_pulse;
            break;
         end
      end
      p_valid[id] = 1'b0;
      if (lat < 0) fail_now("write completion");
      tick();
   endtask

   task automatic chk_seen(input string name, input int idx, input logic [8:0] exp);
      if (idx < seen.size()) chk(name, {7'd0, seen[idx]}, {7'd0, exp});
      else chk(name, 16'hFFFF, {7'd0, exp});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      bit err;
      int ord[$];
      for (int i = 0; i < 2; i++) begin
         p_valid[i] = 1'b0;
         p_row[i]   = 1'b0;
         p_col[i]   = 4'd0;
         p_char[i]  = 8'h00;
      end
      p_drdy = 1'b1;
      drive();
      model_reset();
      @(negedge clk);
      tick();
      tick();
      chk("reset drv_valid", bus.drv_valid, 1'b0);
      chk("reset drv_data", bus.drv_data, 8'h00);
      rst_n = 1'b1;
      tick();

      // Cold cursor: address command then data, ready in cycle 3.
      do_write(0, 1'b0, 4'd3, 8'h41, lat, err);
      chk("t1 latency", 16'(lat), 16'd3);
      chk("t1 bytes", 16'(seen.size()), 16'd2);
      chk_seen("t1 addr", 0, 9'h083);
      chk_seen("t1 char", 1, 9'h141);

      // Cursor hit: data only.
      do_write(0, 1'b0, 4'd4, 8'h42, lat, err);
      chk("t2 latency", 16'(lat), 16'd2);
      chk("t2 bytes", 16'(seen.size()), 16'd1);
      chk_seen("t2 char", 0, 9'h142);

      // Last column invalidates the cursor even though the next cell is adjacent.
      do_write(0, 1'b0, 4'd11, 8'h43, lat, err);
      chk("t3a latency", 16'(lat), 16'd3);
      chk_seen("t3a addr", 0, 9'h08B);
      do_write(1, 1'b1, 4'd0, 8'h44, lat, err);
      chk("t3b latency", 16'(lat), 16'd3);
      chk_seen("t3b addr", 0, 9'h08C);

      // Illegal column: immediate error, no driver traffic.
      do_write(1, 1'b1, 4'd15, 8'h45, lat, err);
      chk("t4 latency", 16'(lat), 16'd1);
      chk("t4 err", err, 1'b1);
      chk("t4 bytes", 16'(seen.size()), 16'd0);

      // Both requesting from reset: 0 first, then strict alternation.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      p_valid[0] = 1'b1;
      p_valid[1] = 1'b1;
      for (int i = 0; i < 400 && ord.size() < 4; i++) begin
         tick();
         if (bus.req0_ready === 1'b1) begin
            ord.push_back(0);
            p_col[0] = 4'($urandom_range(0, COLS - 1));
         end
         if (bus.req1_ready === 1'b1) begin
            ord.push_back(1);
            p_col[1] = 4'($urandom_range(0, COLS - 1));
         end
      end
      p_valid[0] = 1'b0;
      p_valid[1] = 1'b0;
      if (ord.size() < 4) fail_now("alternation");
      for (int k = 0; k < ord.size(); k++) chk("grant order", 16'(ord[k]), 16'(k % 2));
      tick();

      // Stall in SET_ADDR, then reset mid-stall.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      p_valid[0] = 1'b1;
      p_row[0]   = 1'b0;
      p_col[0]   = 4'd7;
      p_char[0]  = 8'h53;
      p_drdy     = 1'b0;
      tick();
      for (int i = 0; i < 100; i++) begin
         tick();
         chk("stall drv_valid", bus.drv_valid, 1'b1);
         chk("stall drv_data", bus.drv_data, 8'h87);
      end
      rst_n = 1'b0;
      #1;
      chk("rst drv_valid", bus.drv_valid, 1'b0);
      chk("rst req0_ready", bus.req0_ready, 1'b0);
      p_valid[0] = 1'b0;
      p_drdy     = 1'b1;
      tick();
      rst_n = 1'b1;
      do_write(0, 1'b0, 4'd7, 8'h53, lat, err);
      chk("t6 latency", 16'(lat), 16'd3);
      chk_seen("t6 addr", 0, 9'h087);

      // Randomized traffic with driver back-pressure and occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if (mq.size() > 0 && !mq[0].is_byte) p_valid[mq[0].id] = 1'b0;
         for (int i = 0; i < 2; i++) begin
            if (!p_valid[i] && $urandom_range(0, 3) == 0) begin
               p_valid[i] = 1'b1;
               p_row[i]   = 1'($urandom_range(0, 1));
               if ($urandom_range(0, 1) == 1) p_col[i] = p_col[i] + 4'd1;
               else p_col[i] = 4'($urandom_range(0, 15));
               p_char[i]  = 8'($urandom_range(0, 255));
            end
         end
         p_drdy = ($urandom_range(0, 3) != 0);
         rst_n  = ($urandom_range(0, 299) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
